// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI RAM burst target.
// Opcodes, FSM state encoding and the read-beat tag.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR_DATA  = 2'b01;
  localparam logic [1:0] OP_RD_ADDR  = 2'b10;
  localparam logic [1:0] OP_RD_BURST = 2'b11;

  localparam logic [1:0] RD_TAG = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

endpackage

// File: rtl/spi_ram_burst_sp_ram.sv
// Single-port synchronous RAM with registered read.
// Contents are never reset.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write on we; read port registers the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder and burst-read FSM in front of sp_ram.
// Pointers auto-increment and wrap at DEPTH.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MAX_BURST = 16
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] data_in,
  input  logic              tx_ready,
  output logic [DATA_W+1:0] data_out,
  output logic              tx_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              cmd_drop
);

  localparam int BW = $clog2(MAX_BURST);
  localparam logic [DATA_W:0] DEPTH_C = (DATA_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [BW:0] beats_q, beats_d;
  logic addr_err_q, addr_err_d;
  logic cmd_drop_q, cmd_drop_d;

  logic [1:0] op;
  logic [DATA_W-1:0] pl;
  logic addr_ok;
  logic we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] rdata;

  function automatic logic [ADDR_W-1:0] ptr_inc(
    input logic [ADDR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign op = data_in[DATA_W+1:DATA_W];
  assign pl = data_in[DATA_W-1:0];
  assign addr_ok = ({1'b0, pl} < DEPTH_C);

  // Write port uses wptr while idle; reads use rptr, held in VALID.
  assign ram_addr = (state_q == IDLE) ? wptr_q : rptr_q;

  sp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (sys_clock),
    .we   (we),
    .addr (ram_addr),
    .wdata(pl),
    .rdata(rdata)
  );

  // State, pointers and pulse outputs.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      beats_q    <= '0;
      addr_err_q <= 1'b0;
      cmd_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      beats_q    <= beats_d;
      addr_err_q <= addr_err_d;
      cmd_drop_q <= cmd_drop_d;
    end
  end

  // Command decode and burst sequencing.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    beats_d    = beats_q;
    addr_err_d = 1'b0;
    cmd_drop_d = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          unique case (op)
            OP_WR_ADDR: begin
              if (addr_ok) wptr_d = pl[ADDR_W-1:0];
              else addr_err_d = 1'b1;
            end
            OP_WR_DATA: begin
              we     = 1'b1;
              wptr_d = ptr_inc(wptr_q);
            end
            OP_RD_ADDR: begin
              if (addr_ok) rptr_d = pl[ADDR_W-1:0];
              else addr_err_d = 1'b1;
            end
            default: begin
              beats_d = (BW+1)'(pl[BW-1:0]) + (BW+1)'(1);
              state_d = FETCH;
            end
          endcase
        end
      end
      FETCH: begin
        cmd_drop_d = rx_valid;
        state_d    = VALID;
      end
      VALID: begin
        cmd_drop_d = rx_valid;
        if (tx_ready) begin
          rptr_d  = ptr_inc(rptr_q);
          beats_d = beats_q - 1'b1;
          state_d = (beats_q == (BW+1)'(1)) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = (state_q == VALID);
  assign busy     = (state_q != IDLE);
  assign data_out = tx_valid ? {RD_TAG, rdata} : '0;
  assign addr_err = addr_err_q;
  assign cmd_drop = cmd_drop_q;

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised memory target behind the SPI slave front-end. It decodes 2-bit-opcode frames from the slave into write-address, write-data, read-address and burst-read commands. Write and read pointers auto-increment and wrap. Read data returns through a valid/ready handshake with back-pressure.

## Interface
Parameters:
- DATA_W, 16, payload/word width
- DEPTH, 512, number of words
- ADDR_W, $clog2(DEPTH), pointer width
- MAX_BURST, 16, maximum beats per read command (power of two)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- sys_clock  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  data_in holds a command frame this cycle
- data_in  in  DATA_W+2  frame: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
- tx_ready  in  1  slave accepts data_out this cycle
- data_out  out  DATA_W+2  read beat: {2'b11, word}; all-zero when tx_valid=0
- tx_valid  out  1  data_out valid
- busy  out  1  burst in progress; commands not accepted
- addr_err  out  1  one-cycle pulse: address payload ≥ DEPTH
- cmd_drop  out  1  one-cycle pulse: rx_valid while busy

## Operation
- Opcodes:
  - 00 WR_ADDR: wptr ← payload.
  - 01 WR_DATA: mem[wptr] ← payload; wptr ← wptr+1 mod DEPTH.
  - 10 RD_ADDR: rptr ← payload.
  - 11 RD_BURST: start burst of N = payload[$clog2(MAX_BURST)-1:0]+1 beats from rptr.
- Address check for 00/10: payload ≥ DEPTH → pointer unchanged, addr_err pulses. Upper payload bits above ADDR_W must be zero.
- FSM states:
  - IDLE: commands accepted. RD_BURST → FETCH, beats_left ← N.
  - FETCH: one cycle, memory read at rptr. → VALID.
  - VALID: tx_valid=1, data_out held stable until tx_ready.
    - On handshake: rptr ← rptr+1 mod DEPTH, beats_left−1.
    - If beats remain → FETCH; else → IDLE.
- busy=1 in FETCH and VALID.
- rx_valid while busy: frame discarded entirely (no pointer or memory change), cmd_drop pulses.
- rx_valid=0: no state change.
- Memory contents are not reset. Only pointers, FSM and outputs are reset.
- Pointer wrap: DEPTH−1 → 0 for both pointers. Bursts may cross the wrap point.

## Timing
- Reset values:
  - data_out=0, tx_valid=0, busy=0, addr_err=0, cmd_drop=0
  - wptr=0, rptr=0, state IDLE
- Reset mid-burst aborts immediately (asynchronous). No further beats.
- WR_ADDR, WR_DATA, RD_ADDR take effect at the edge sampling rx_valid. A WR_DATA in the cycle after WR_ADDR uses the new wptr.
- RD_BURST accepted at edge E0:
  - busy=1 after E0.
  - First tx_valid=1 after E1 (one FETCH cycle; synchronous memory read).
- Each beat:
  - Handshake edge, then one FETCH bubble cycle, then the next beat valid. Throughput is 1 beat per 2 cycles with tx_ready held high.
  - Last handshake edge → busy=0 and tx_valid=0 in the following cycle. A new command is accepted in that cycle.
- addr_err and cmd_drop assert in the cycle after the offending edge, for exactly one cycle.

## Structure
- Shared package spi_ram_pkg:
  - opcode localparams (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_BURST)
  - FSM state enum (IDLE, FETCH, VALID)
  - read tag constant 2'b11
- One sub-module: sp_ram, a single-port synchronous RAM.
  - Parameters DATA_W, DEPTH. Ports: we, addr, wdata, rdata; registered read.
  - The address mux selects wptr in IDLE and rptr in FETCH. The FSM guarantees no port conflict.

## Test plan
- Reset: assert reset_n=0 mid-operation → all outputs 0 asynchronously. After release, WR_DATA 0x00FF followed by a 1-beat read from address 0 → 0x300FF.
- Basic burst:
  - WR_ADDR 0x010; WR_DATA 0xAAAA, 0x5555, 0x1234.
  - RD_ADDR 0x010; RD_BURST payload 2; tx_ready=1.
  - Expect beats 0x3AAAA, 0x35555, 0x31234, each tx_valid for 1 cycle with a 1-cycle gap. busy falls after the third.
- Wrap:
  - WR_ADDR 511; WR_DATA 0x1111, 0x2222.
  - RD_ADDR 511; RD_BURST payload 1 → 0x31111, then 0x32222 (read from address 0).
- Back-pressure: tx_ready=0 for 5 cycles during a beat → data_out and tx_valid stable. Beat count and rptr unchanged until tx_ready=1.
- Address error (DEPTH=512): WR_ADDR 0x0258 → addr_err 1-cycle pulse. A following WR_DATA 0xBEEF lands at the prior wptr, confirmed by readback.
- Busy collision: WR_DATA 0xDEAD issued during a burst → cmd_drop pulse, memory and wptr unchanged. The burst completes normally.
